// File: rtl/decode_issue_pkg.sv
// Shared types and default geometry for the decode-issue stage.
// Contents:
//   DEF_*         default parameter values used by decode_issue_stage
//   DEF_VW        default vector word width (elements * element width)
//   ctrl_t        opaque decoded-control bundle at the default width
//   idex_t        ID/EX register layout at the default geometry
//   vec_word_bits helper that derives a vector word width
package decode_issue_pkg;

  localparam int unsigned DEF_REGI_BITS = 4;
  localparam int unsigned DEF_VECT_BITS = 2;
  localparam int unsigned DEF_REGI_SIZE = 16;
  localparam int unsigned DEF_VECT_SIZE = 8;
  localparam int unsigned DEF_ELEM_SIZE = 8;
  localparam int unsigned DEF_CTRL_W    = 32;
  localparam int unsigned DEF_VW        = DEF_VECT_SIZE * DEF_ELEM_SIZE;

  typedef logic [DEF_CTRL_W-1:0] ctrl_t;

  typedef struct packed {
    logic [DEF_REGI_SIZE-1:0] int_op1;
    logic [DEF_REGI_SIZE-1:0] int_op2;
    logic [DEF_VW-1:0]        vec_op1;
    logic [DEF_VW-1:0]        vec_op2;
    logic [DEF_REGI_BITS-1:0] idst;
    logic                     idst_en;
    logic [DEF_VECT_BITS-1:0] vdst;
    logic                     vdst_en;
    ctrl_t                    ctrl;
  } idex_t;

  function automatic int unsigned vec_word_bits(input int unsigned vect_size,
                                                input int unsigned elem_size);
    return vect_size * elem_size;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   set_a_*/set_b_*           mark a register as having a write in flight
//   clr_*                     write-back; clears the bit and is bypassed into queries
//   kill_*                    drop a pending write (flushed instruction)
//   query_idx_i / busy_o      three lookups; busy means "still waiting on a write"
// A set in the same cycle as a clear of the same index leaves the bit set.
module reg_scoreboard #(
  parameter int unsigned BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_a_en_i,
  input  logic [BITS-1:0]      set_a_idx_i,
  input  logic                 set_b_en_i,
  input  logic [BITS-1:0]      set_b_idx_i,
  input  logic                 clr_en_i,
  input  logic [BITS-1:0]      clr_idx_i,
  input  logic                 kill_en_i,
  input  logic [BITS-1:0]      kill_idx_i,
  input  logic [2:0][BITS-1:0] query_idx_i,
  output logic [2:0]           busy_o
);

  localparam int unsigned NumRegs = 1 << BITS;

  logic [NumRegs-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (kill_en_i) pending_d[kill_idx_i] = 1'b0;
    if (clr_en_i)  pending_d[clr_idx_i]  = 1'b0;
    // Sets last so a new producer outranks a retiring one.
    if (set_a_en_i) pending_d[set_a_idx_i] = 1'b1;
    if (set_b_en_i) pending_d[set_b_idx_i] = 1'b1;
  end

  // A write-back landing this cycle already satisfies the dependency.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      busy_o[k] = pending_q[query_idx_i[k]] && !(clr_en_i && (clr_idx_i == query_idx_i[k]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode-issue stage: int and vector register files with write-through bypass,
// pending-write scoreboards that stall on RAW/WAW hazards, and an ID/EX register
// with valid/ready handshake and flush.
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   in_valid_i / in_ready_o          decoded instruction handshake
//   isrc*/vsrc*/idst*/vdst*/ctrl_i   decoded fields; pc_i feeds the PC alias register
//   int_w*/vec_w*                    write-back ports
//   flush_i                          kill the instruction held in ID/EX
//   out_valid_o / out_ready_i        EX handshake
//   *_op*_o, *dst*_o, ctrl_o         registered operands, destinations, control
//   stall_o                          instruction present but blocked by a hazard
module decode_issue_stage
  import decode_issue_pkg::*;
#(
  parameter int unsigned REGI_BITS = DEF_REGI_BITS,
  parameter int unsigned VECT_BITS = DEF_VECT_BITS,
  parameter int unsigned REGI_SIZE = DEF_REGI_SIZE,
  parameter int unsigned VECT_SIZE = DEF_VECT_SIZE,
  parameter int unsigned ELEM_SIZE = DEF_ELEM_SIZE,
  parameter int unsigned CTRL_W    = DEF_CTRL_W,
  parameter bit          PC_ALIAS  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [REGI_BITS-1:0]           isrc1_i,
  input  logic [REGI_BITS-1:0]           isrc2_i,
  input  logic [1:0]                     isrc_en_i,
  input  logic [VECT_BITS-1:0]           vsrc1_i,
  input  logic [VECT_BITS-1:0]           vsrc2_i,
  input  logic [1:0]                     vsrc_en_i,
  input  logic [REGI_BITS-1:0]           idst_i,
  input  logic                           idst_en_i,
  input  logic [VECT_BITS-1:0]           vdst_i,
  input  logic                           vdst_en_i,
  input  logic [CTRL_W-1:0]              ctrl_i,
  input  logic [REGI_SIZE-1:0]           pc_i,
  input  logic                           int_we_i,
  input  logic [REGI_BITS-1:0]           int_wa_i,
  input  logic [REGI_SIZE-1:0]           int_wd_i,
  input  logic                           vec_we_i,
  input  logic [VECT_BITS-1:0]           vec_wa_i,
  input  logic [VECT_SIZE*ELEM_SIZE-1:0] vec_wd_i,
  input  logic                           flush_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [REGI_SIZE-1:0]           int_op1_o,
  output logic [REGI_SIZE-1:0]           int_op2_o,
  output logic [VECT_SIZE*ELEM_SIZE-1:0] vec_op1_o,
  output logic [VECT_SIZE*ELEM_SIZE-1:0] vec_op2_o,
  output logic [REGI_BITS-1:0]           idst_o,
  output logic                           idst_en_o,
  output logic [VECT_BITS-1:0]           vdst_o,
  output logic                           vdst_en_o,
  output logic [CTRL_W-1:0]              ctrl_o,
  output logic                           stall_o
);

  localparam int unsigned VW     = vec_word_bits(VECT_SIZE, ELEM_SIZE);
  localparam int unsigned NumInt = 1 << REGI_BITS;
  localparam int unsigned NumVec = 1 << VECT_BITS;

  typedef struct packed {
    logic [REGI_SIZE-1:0] int_op1;
    logic [REGI_SIZE-1:0] int_op2;
    logic [VW-1:0]        vec_op1;
    logic [VW-1:0]        vec_op2;
    logic [REGI_BITS-1:0] idst;
    logic                 idst_en;
    logic [VECT_BITS-1:0] vdst;
    logic                 vdst_en;
    logic [CTRL_W-1:0]    ctrl;
  } stage_t;

  // ---------------------------------------------------------------------------
  // Register files
  // ---------------------------------------------------------------------------
  logic [REGI_SIZE-1:0] int_rf_q [NumInt];
  logic [VW-1:0]        vec_rf_q [NumVec];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NumInt; i++) int_rf_q[i] <= '0;
      for (int i = 0; i < NumVec; i++) vec_rf_q[i] <= '0;
    end else begin
      if (int_we_i) int_rf_q[int_wa_i] <= int_wd_i;
      if (vec_we_i) vec_rf_q[vec_wa_i] <= vec_wd_i;
    end
  end

  // Priority: disabled -> 0, PC alias, same-cycle write-back, stored value.
  function automatic logic [REGI_SIZE-1:0] int_pick(
    input logic                 en,
    input logic [REGI_BITS-1:0] idx,
    input logic [REGI_SIZE-1:0] stored,
    input logic [REGI_SIZE-1:0] pc,
    input logic                 we,
    input logic [REGI_BITS-1:0] wa,
    input logic [REGI_SIZE-1:0] wd
  );
    if (!en)                   return '0;
    if (PC_ALIAS && (&idx))    return pc;
    if (we && (wa == idx))     return wd;
    return stored;
  endfunction

  function automatic logic [VW-1:0] vec_pick(
    input logic                 en,
    input logic [VECT_BITS-1:0] idx,
    input logic [VW-1:0]        stored,
    input logic                 we,
    input logic [VECT_BITS-1:0] wa,
    input logic [VW-1:0]        wd
  );
    if (!en)               return '0;
    if (we && (wa == idx)) return wd;
    return stored;
  endfunction

  logic [REGI_SIZE-1:0] int_op1_d, int_op2_d;
  logic [VW-1:0]        vec_op1_d, vec_op2_d;

  assign int_op1_d = int_pick(isrc_en_i[0], isrc1_i, int_rf_q[isrc1_i], pc_i,
                              int_we_i, int_wa_i, int_wd_i);
  assign int_op2_d = int_pick(isrc_en_i[1], isrc2_i, int_rf_q[isrc2_i], pc_i,
                              int_we_i, int_wa_i, int_wd_i);
  assign vec_op1_d = vec_pick(vsrc_en_i[0], vsrc1_i, vec_rf_q[vsrc1_i],
                              vec_we_i, vec_wa_i, vec_wd_i);
  assign vec_op2_d = vec_pick(vsrc_en_i[1], vsrc2_i, vec_rf_q[vsrc2_i],
                              vec_we_i, vec_wa_i, vec_wd_i);

  // ---------------------------------------------------------------------------
  // Scoreboards and handshake
  // ---------------------------------------------------------------------------
  stage_t idex_q, idex_d;
  logic   out_valid_q, out_valid_d;
  logic   issue, hazard, flush_kill;
  logic [2:0] int_busy, vec_busy;

  // Flush only retires pending bits if there is a live entry to kill.
  assign flush_kill = flush_i && out_valid_q;

  reg_scoreboard #(
    .BITS (REGI_BITS)
  ) u_int_sb (
    .clk         (clk),
    .rst         (rst),
    .set_a_en_i  (issue && idst_en_i),
    .set_a_idx_i (idst_i),
    .set_b_en_i  (1'b0),
    .set_b_idx_i ('0),
    .clr_en_i    (int_we_i),
    .clr_idx_i   (int_wa_i),
    .kill_en_i   (flush_kill && idex_q.idst_en),
    .kill_idx_i  (idex_q.idst),
    .query_idx_i ({idst_i, isrc2_i, isrc1_i}),
    .busy_o      (int_busy)
  );

  reg_scoreboard #(
    .BITS (VECT_BITS)
  ) u_vec_sb (
    .clk         (clk),
    .rst         (rst),
    .set_a_en_i  (issue && vdst_en_i),
    .set_a_idx_i (vdst_i),
    .set_b_en_i  (1'b0),
    .set_b_idx_i ('0),
    .clr_en_i    (vec_we_i),
    .clr_idx_i   (vec_wa_i),
    .kill_en_i   (flush_kill && idex_q.vdst_en),
    .kill_idx_i  (idex_q.vdst),
    .query_idx_i ({vdst_i, vsrc2_i, vsrc1_i}),
    .busy_o      (vec_busy)
  );

  assign hazard = (isrc_en_i[0] && int_busy[0]) || (isrc_en_i[1] && int_busy[1]) ||
                  (idst_en_i    && int_busy[2]) ||
                  (vsrc_en_i[0] && vec_busy[0]) || (vsrc_en_i[1] && vec_busy[1]) ||
                  (vdst_en_i    && vec_busy[2]);

  assign in_ready_o = !hazard && !flush_i && (!out_valid_q || out_ready_i);
  assign stall_o    = in_valid_i && hazard;
  assign issue      = in_valid_i && in_ready_o;

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  always_comb begin
    idex_d      = idex_q;
    out_valid_d = out_valid_q;
    if (issue) begin
      idex_d.int_op1 = int_op1_d;
      idex_d.int_op2 = int_op2_d;
      idex_d.vec_op1 = vec_op1_d;
      idex_d.vec_op2 = vec_op2_d;
      idex_d.idst    = idst_i;
      idex_d.idst_en = idst_en_i;
      idex_d.vdst    = vdst_i;
      idex_d.vdst_en = vdst_en_i;
      idex_d.ctrl    = ctrl_i;
      out_valid_d    = 1'b1;
    end else if (flush_i || out_ready_i) begin
      // Data fields hold; only the valid bit drops.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      idex_q      <= idex_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign int_op1_o   = idex_q.int_op1;
  assign int_op2_o   = idex_q.int_op2;
  assign vec_op1_o   = idex_q.vec_op1;
  assign vec_op2_o   = idex_q.vec_op2;
  assign idst_o      = idex_q.idst;
  assign idst_en_o   = idex_q.idst_en;
  assign vdst_o      = idex_q.vdst;
  assign vdst_en_o   = idex_q.vdst_en;
  assign ctrl_o      = idex_q.ctrl;

endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [3:0]  isrc1_i, isrc2_i;
  logic [1:0]  isrc_en_i;
  logic [1:0]  vsrc1_i, vsrc2_i;
  logic [1:0]  vsrc_en_i;
  logic [3:0]  idst_i;
  logic        idst_en_i;
  logic [1:0]  vdst_i;
  logic        vdst_en_i;
  logic [31:0] ctrl_i;
  logic [15:0] pc_i;
  logic        int_we_i;
  logic [3:0]  int_wa_i;
  logic [15:0] int_wd_i;
  logic        vec_we_i;
  logic [1:0]  vec_wa_i;
  logic [63:0] vec_wd_i;
  logic        flush_i;
  logic        out_valid_o, out_ready_i;
  logic [15:0] int_op1_o, int_op2_o;
  logic [63:0] vec_op1_o, vec_op2_o;
  logic [3:0]  idst_o;
  logic        idst_en_o;
  logic [1:0]  vdst_o;
  logic        vdst_en_o;
  logic [31:0] ctrl_o;
  logic        stall_o;

  decode_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .isrc1_i     (isrc1_i),
    .isrc2_i     (isrc2_i),
    .isrc_en_i   (isrc_en_i),
    .vsrc1_i     (vsrc1_i),
    .vsrc2_i     (vsrc2_i),
    .vsrc_en_i   (vsrc_en_i),
    .idst_i      (idst_i),
    .idst_en_i   (idst_en_i),
    .vdst_i      (vdst_i),
    .vdst_en_i   (vdst_en_i),
    .ctrl_i      (ctrl_i),
    .pc_i        (pc_i),
    .int_we_i    (int_we_i),
    .int_wa_i    (int_wa_i),
    .int_wd_i    (int_wd_i),
    .vec_we_i    (vec_we_i),
    .vec_wa_i    (vec_wa_i),
    .vec_wd_i    (vec_wd_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .int_op1_o   (int_op1_o),
    .int_op2_o   (int_op2_o),
    .vec_op1_o   (vec_op1_o),
    .vec_op2_o   (vec_op2_o),
    .idst_o      (idst_o),
    .idst_en_o   (idst_en_o),
    .vdst_o      (vdst_o),
    .vdst_en_o   (vdst_en_o),
    .ctrl_o      (ctrl_o),
    .stall_o     (stall_o)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] V0 = 64'h0011_2233_4455_6677;
  localparam logic [63:0] V1 = 64'h8899_AABB_CCDD_EEFF;
  localparam logic [63:0] V3 = 64'hDEAD_BEEF_CAFE_F00D;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  isrc1, isrc2;
    logic [1:0]  isrc_en;
    logic [1:0]  vsrc1, vsrc2;
    logic [1:0]  vsrc_en;
    logic        iwe;
    logic [3:0]  iwa;
    logic [15:0] iwd;
    logic        vwe;
    logic [1:0]  vwa;
    logic [63:0] vwd;
    logic [15:0] pc;
    logic [31:0] ctrl;
    logic [15:0] e_i1, e_i2;
    logic [63:0] e_v1, e_v2;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid_i  = 1'b0;
    isrc1_i = '0; isrc2_i = '0; isrc_en_i = '0;
    vsrc1_i = '0; vsrc2_i = '0; vsrc_en_i = '0;
    idst_i  = '0; idst_en_i = 1'b0;
    vdst_i  = '0; vdst_en_i = 1'b0;
    ctrl_i  = '0; pc_i = '0;
    int_we_i = 1'b0; int_wa_i = '0; int_wd_i = '0;
    vec_we_i = 1'b0; vec_wa_i = '0; vec_wd_i = '0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic int_wb(input logic [3:0] wa, input logic [15:0] wd);
    idle();
    int_we_i = 1'b1; int_wa_i = wa; int_wd_i = wd;
    tick();
  endtask

  task automatic vec_wb(input logic [1:0] wa, input logic [63:0] wd);
    idle();
    vec_we_i = 1'b1; vec_wa_i = wa; vec_wd_i = wd;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{4'd1, 4'd2, 2'b11, 2'd0, 2'd3, 2'b11, 1'b0, 4'd0, 16'h0, 1'b0, 2'd0, 64'h0,
               16'h0000, 32'hA5A5_0001, 16'h1111, 16'h2222, V0, V3};
    tbl[1] = '{4'd4, 4'd1, 2'b01, 2'd2, 2'd0, 2'b10, 1'b0, 4'd0, 16'h0, 1'b0, 2'd0, 64'h0,
               16'h0000, 32'hA5A5_0002, 16'h4444, 16'h0000, 64'h0, V0};
    tbl[2] = '{4'd6, 4'd15, 2'b11, 2'd1, 2'd0, 2'b01, 1'b1, 4'd6, 16'h6666, 1'b1, 2'd1, V1,
               16'h0042, 32'hA5A5_0003, 16'h6666, 16'h0042, V1, 64'h0};
    tbl[3] = '{4'd15, 4'd6, 2'b11, 2'd1, 2'd3, 2'b11, 1'b1, 4'd15, 16'h7777, 1'b0, 2'd0, 64'h0,
               16'h0099, 32'hA5A5_0004, 16'h0099, 16'h6666, V1, V3};
    tbl[4] = '{4'd2, 4'd0, 2'b11, 2'd0, 2'd0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b0, 2'd0, 64'h0,
               16'h0000, 32'hA5A5_0005, 16'h2222, 16'h0000, 64'h0, 64'h0};

    // Reset, with write-backs in flight that must be dropped.
    idle();
    rst = 1'b0;
    int_we_i = 1'b1; int_wa_i = 4'd3; int_wd_i = 16'hBEEF;
    vec_we_i = 1'b1; vec_wa_i = 2'd2; vec_wd_i = V1;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_int_op1", 64'(int_op1_o), 64'd0);
    check("rst_vec_op1", vec_op1_o, 64'd0);
    check("rst_idst_en", 64'(idst_en_o), 64'd0);
    check("rst_ctrl", 64'(ctrl_o), 64'd0);

    // First issue after reset reads zeroed register files.
    rst = 1'b1;
    idle();
    in_valid_i = 1'b1;
    isrc1_i = 4'd3; isrc_en_i = 2'b01;
    vsrc1_i = 2'd2; vsrc_en_i = 2'b01;
    ctrl_i = 32'hC0DE_0001;
    #1 check("t1_in_ready", 64'(in_ready_o), 64'd1);
    tick();
    check("t1_out_valid", 64'(out_valid_o), 64'd1);
    check("t1_int_op1", 64'(int_op1_o), 64'd0);
    check("t1_vec_op1", vec_op1_o, 64'd0);
    check("t1_ctrl", 64'(ctrl_o), 64'hC0DE_0001);

    // Preload through the write-back ports.
    int_wb(4'd1, 16'h1111);
    check("drain_out_valid", 64'(out_valid_o), 64'd0);
    int_wb(4'd2, 16'h2222);
    int_wb(4'd4, 16'h4444);
    vec_wb(2'd0, V0);
    vec_wb(2'd3, V3);

    // Back-to-back independent issues.
    for (int i = 0; i < 5; i++) begin
      idle();
      in_valid_i = 1'b1;
      isrc1_i = tbl[i].isrc1; isrc2_i = tbl[i].isrc2; isrc_en_i = tbl[i].isrc_en;
      vsrc1_i = tbl[i].vsrc1; vsrc2_i = tbl[i].vsrc2; vsrc_en_i = tbl[i].vsrc_en;
      int_we_i = tbl[i].iwe; int_wa_i = tbl[i].iwa; int_wd_i = tbl[i].iwd;
      vec_we_i = tbl[i].vwe; vec_wa_i = tbl[i].vwa; vec_wd_i = tbl[i].vwd;
      pc_i = tbl[i].pc; ctrl_i = tbl[i].ctrl;
      #1 check($sformatf("tbl%0d_in_ready", i), 64'(in_ready_o), 64'd1);
      tick();
      check($sformatf("tbl%0d_out_valid", i), 64'(out_valid_o), 64'd1);
      check($sformatf("tbl%0d_int_op1", i), 64'(int_op1_o), 64'(tbl[i].e_i1));
      check($sformatf("tbl%0d_int_op2", i), 64'(int_op2_o), 64'(tbl[i].e_i2));
      check($sformatf("tbl%0d_vec_op1", i), vec_op1_o, tbl[i].e_v1);
      check($sformatf("tbl%0d_vec_op2", i), vec_op2_o, tbl[i].e_v2);
      check($sformatf("tbl%0d_ctrl", i), 64'(ctrl_o), 64'(tbl[i].ctrl));
    end

    // RAW: consumer of r5 stalls until the write-back, then issues that same cycle.
    idle();
    in_valid_i = 1'b1; idst_i = 4'd5; idst_en_i = 1'b1;
    tick();
    check("raw_prod_idst", 64'(idst_o), 64'd5);
    check("raw_prod_idst_en", 64'(idst_en_o), 64'd1);
    idle();
    in_valid_i = 1'b1; isrc1_i = 4'd5; isrc_en_i = 2'b01;
    #1 check("raw_stall", 64'(stall_o), 64'd1);
    check("raw_in_ready", 64'(in_ready_o), 64'd0);
    tick();
    check("raw_consumed", 64'(out_valid_o), 64'd0);
    check("raw_still_stall", 64'(stall_o), 64'd1);
    int_we_i = 1'b1; int_wa_i = 4'd5; int_wd_i = 16'h1234;
    #1 check("raw_wb_stall", 64'(stall_o), 64'd0);
    check("raw_wb_in_ready", 64'(in_ready_o), 64'd1);
    tick();
    check("raw_issue_valid", 64'(out_valid_o), 64'd1);
    check("raw_issue_op1", 64'(int_op1_o), 64'h1234);

    // Backpressure: held entry stays put, next instruction waits for out_ready.
    idle();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; isrc1_i = 4'd1; isrc_en_i = 2'b01;
    #1 check("bp_in_ready", 64'(in_ready_o), 64'd0);
    check("bp_stall", 64'(stall_o), 64'd0);
    tick();
    check("bp_hold_valid", 64'(out_valid_o), 64'd1);
    check("bp_hold_op1", 64'(int_op1_o), 64'h1234);
    out_ready_i = 1'b1;
    #1 check("bp_release_ready", 64'(in_ready_o), 64'd1);
    tick();
    check("bp_next_op1", 64'(int_op1_o), 64'h1111);

    // Flush drops the vdst=1 producer and its pending bit.
    idle();
    in_valid_i = 1'b1; vdst_i = 2'd1; vdst_en_i = 1'b1;
    tick();
    check("fl_vdst", 64'(vdst_o), 64'd1);
    check("fl_vdst_en", 64'(vdst_en_o), 64'd1);
    idle();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; vsrc1_i = 2'd1; vsrc_en_i = 2'b01;
    #1 check("fl_pre_stall", 64'(stall_o), 64'd1);
    flush_i = 1'b1;
    #1 check("fl_in_ready", 64'(in_ready_o), 64'd0);
    tick();
    check("fl_out_valid", 64'(out_valid_o), 64'd0);
    flush_i = 1'b0;
    #1 check("fl_post_stall", 64'(stall_o), 64'd0);
    check("fl_post_ready", 64'(in_ready_o), 64'd1);
    tick();
    check("fl_post_valid", 64'(out_valid_o), 64'd1);
    check("fl_post_vec_op1", vec_op1_o, V1);

    // WAW: pending r7 re-targeted while r7 retires; the new write keeps it pending.
    idle();
    in_valid_i = 1'b1; idst_i = 4'd7; idst_en_i = 1'b1;
    tick();
    int_we_i = 1'b1; int_wa_i = 4'd7; int_wd_i = 16'h7070;
    #1 check("waw_stall", 64'(stall_o), 64'd0);
    check("waw_in_ready", 64'(in_ready_o), 64'd1);
    tick();
    check("waw_idst", 64'(idst_o), 64'd7);
    check("waw_valid", 64'(out_valid_o), 64'd1);
    idle();
    in_valid_i = 1'b1; isrc1_i = 4'd7; isrc_en_i = 2'b01;
    #1 check("waw_pending_kept", 64'(stall_o), 64'd1);
    int_we_i = 1'b1; int_wa_i = 4'd7; int_wd_i = 16'h0777;
    #1 check("waw_release", 64'(stall_o), 64'd0);
    tick();
    check("waw_op1", 64'(int_op1_o), 64'h0777);

    // Reset mid-operation: pending r9 and an in-flight write-back both vanish.
    idle();
    in_valid_i = 1'b1; idst_i = 4'd9; idst_en_i = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    int_we_i = 1'b1; int_wa_i = 4'd9; int_wd_i = 16'h9999;
    tick();
    check("mrst_valid", 64'(out_valid_o), 64'd0);
    check("mrst_idst_en", 64'(idst_en_o), 64'd0);
    check("mrst_op1", 64'(int_op1_o), 64'd0);
    rst = 1'b1;
    idle();
    in_valid_i = 1'b1; isrc1_i = 4'd9; isrc2_i = 4'd1; isrc_en_i = 2'b11;
    #1 check("mrst_no_stall", 64'(stall_o), 64'd0);
    tick();
    check("mrst_r9", 64'(int_op1_o), 64'd0);
    check("mrst_r1", 64'(int_op2_o), 64'd0);

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised decode-issue stage: int and vector register files, a pending-write scoreboard that stalls on RAW/WAW hazards, write-back bypass, and an ID/EX pipeline register with valid/ready handshake and flush. Successor to the fixed decode/regfile/ID-EX wrapper. Sits between the instruction decoder, which supplies already-decoded fields, and the int/vector ALUs, memory and swap units.

## Interface
- REGI_BITS, 4, int register index width; 2**REGI_BITS registers
- VECT_BITS, 2, vector register index width
- REGI_SIZE, 16, int register width
- VECT_SIZE, 8, elements per vector
- ELEM_SIZE, 8, element width; vector word VW = VECT_SIZE*ELEM_SIZE
- CTRL_W, 32, width of the opaque decoded-control bundle carried to EX
- PC_ALIAS, 1, 1: reads of int index 2**REGI_BITS-1 return pc_i
- clk in 1 system clock
- rst in 1 reset; synchronous, active-low
- in_valid_i in 1 decoded instruction present
- in_ready_o out 1 instruction accepted this cycle when high with in_valid_i
- isrc1_i, isrc2_i in REGI_BITS int source indices; isrc_en_i in 2 per-source use
- vsrc1_i, vsrc2_i in VECT_BITS vector source indices; vsrc_en_i in 2 per-source use
- idst_i in REGI_BITS, idst_en_i in 1 int destination
- vdst_i in VECT_BITS, vdst_en_i in 1 vector destination
- ctrl_i in CTRL_W decoded control bundle; pc_i in REGI_SIZE next PC
- int_we_i in 1, int_wa_i in REGI_BITS, int_wd_i in REGI_SIZE int write-back
- vec_we_i in 1, vec_wa_i in VECT_BITS, vec_wd_i in VW vector write-back
- flush_i in 1 kill the instruction held in ID/EX (taken jump)
- out_valid_o out 1, out_ready_i in 1 EX handshake
- int_op1_o, int_op2_o out REGI_SIZE; vec_op1_o, vec_op2_o out VW operands
- idst_o, idst_en_o, vdst_o, vdst_en_o, ctrl_o out destinations/control registered
- stall_o out 1 in_valid_i high and hazard present

## Operation
- Hazard: any enabled source or enabled destination has its pending bit set and is not written back this cycle with matching index. WAW stalls like RAW.
- in_ready_o = !hazard && !flush_i && (!out_valid_o || out_ready_i); stall_o = in_valid_i && hazard.
- Operand read combinational; same-cycle write-back to the read index is bypassed (write-through). PC alias overrides bypass; writes to the alias index are still stored.
- Issue (in_valid_i && in_ready_o): ID/EX loads operands, dests, ctrl; out_valid_o<=1; pending bit of each enabled dest set.
- Write-back clears pending bit of its index; if issue sets the same index in the same cycle, set wins.
- EX consumes (out_valid_o && out_ready_i, no issue): out_valid_o<=0; data fields hold.
- flush_i: out_valid_o<=0, pending bits of the flushed entry's enabled dests cleared (unless a same-cycle issue sets them; none can, since in_ready_o=0). No effect if out_valid_o=0.
- Disabled sources ignore pending bits and output 0.
- Reset: all register-file entries, pending bits, out_valid_o and every registered output to 0.

## Timing
- Accept at edge N -> out_valid_o high after edge N, operands valid same cycle.
- Back-to-back dependent issue: producer write-back in cycle M unblocks consumer in cycle M (bypass), zero bubble beyond write-back.
- Full-throughput when independent: one issue per cycle while out_ready_i=1.
- Register-file write at clock edge; scoreboard update at the same edge.
- Reset mid-operation: next cycle all state is the reset value, and in-flight write-backs during reset are dropped.

## Structure
- Package decode_issue_pkg: VW, ctrl_t (logic [CTRL_W-1:0]), idex_t packed struct of registered outputs.
- Sub-module reg_scoreboard #(BITS): set/clear ports for two set sources and one clear, query for up to three indices; instantiated once for int, once for vector.
- Register files inline (array plus bypass mux).

## Test plan
- Reset then read isrc1=3, vsrc1=2 -> int_op1_o=0, vec_op1_o=0, out_valid_o=1 next cycle.
- Issue idst=5; next instr src 5 -> stall_o=1, in_ready_o=0 until int_we_i with wa=5, wd=0x1234, which issues the same cycle with int_op1_o=0x1234 next cycle.
- out_ready_i=0 with valid entry -> in_ready_o=0, outputs stable; raise out_ready_i -> next instr accepted same cycle.
- Flush while entry with vdst=1 valid -> out_valid_o=0, later read of vsrc1=1 does not stall.
- PC_ALIAS=1, isrc2=15, pc_i=0x0042 -> int_op2_o=0x0042.
- WAW: pending idst=7, new instr idst=7 and write-back wa=7 same cycle -> issues, pending[7] remains set.
